// File: rtl/fp16_mul_sched.sv
// Round-robin scheduler that time-shares one external combinational FP16 multiplier
// between two requesters and returns id-tagged products on a single response channel.
module fp16_mul_sched #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_y,
    output logic        rsp_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mul_a_q, mul_a_d;
    logic [15:0] mul_b_q, mul_b_d;
    logic [15:0] rsp_y_q, rsp_y_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        grant;
    logic        accept;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
    assign req1_ready = (state_q == IDLE) &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_y_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_y_q      <= rsp_y_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = WAIT;
            WAIT: if (cnt_q == 4'd1) state_d = DONE;
            DONE: if (rsp_valid_q && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_y_d      = rsp_y_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_a_d      = grant ? req1_a : req0_a;
                    mul_b_d      = grant ? req1_b : req0_b;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    cnt_d        = 4'(MUL_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_y_d     = mul_y;
                    rsp_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp16_mul_sched.sv
// Directed bench for fp16_mul_sched: table of single transactions plus hand-written
// sequences for backpressure, operand stability, mid-operation reset, fairness and MUL_LAT=1.
module tb_fp16_mul_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] mul_a, mul_b, mul_y, rsp_y;
    logic        rsp_valid, rsp_ready, rsp_id, busy;

    logic        p1_req0_valid, p1_req1_valid, p1_req0_ready, p1_req1_ready;
    logic [15:0] p1_req0_a, p1_req0_b, p1_req1_a, p1_req1_b;
    logic [15:0] p1_mul_a, p1_mul_b, p1_mul_y, p1_rsp_y;
    logic        p1_rsp_valid, p1_rsp_ready, p1_rsp_id, p1_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stand-in multiplier: exact FP16 products for the operand pairs used here.
    function automatic logic [15:0] fake_mul(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h4000_4200: return 16'h4600;
            32'h3C00_3C00: return 16'h3C00;
            32'h4000_4000: return 16'h4400;
            32'h0000_4000: return 16'h0000;
            32'h3800_4000: return 16'h3C00;
            32'hC000_4200: return 16'hC600;
            default:       return 16'hDEAD;
        endcase
    endfunction

    assign mul_y    = fake_mul(mul_a, mul_b);
    assign p1_mul_y = fake_mul(p1_mul_a, p1_mul_b);

    fp16_mul_sched #(.MUL_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
        .busy(busy)
    );

    fp16_mul_sched #(.MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(p1_req0_valid), .req0_ready(p1_req0_ready), .req0_a(p1_req0_a), .req0_b(p1_req0_b),
        .req1_valid(p1_req1_valid), .req1_ready(p1_req1_ready), .req1_a(p1_req1_a), .req1_b(p1_req1_b),
        .mul_a(p1_mul_a), .mul_b(p1_mul_b), .mul_y(p1_mul_y),
        .rsp_valid(p1_rsp_valid), .rsp_ready(p1_rsp_ready), .rsp_y(p1_rsp_y), .rsp_id(p1_rsp_id),
        .busy(p1_busy)
    );

    typedef struct {
        logic        sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;

        vecs[0] = '{sel: 1'b0, a: 16'h4000, b: 16'h4200, y: 16'h4600};
        vecs[1] = '{sel: 1'b1, a: 16'h0000, b: 16'h4000, y: 16'h0000};
        vecs[2] = '{sel: 1'b0, a: 16'h3C00, b: 16'h3C00, y: 16'h3C00};
        vecs[3] = '{sel: 1'b1, a: 16'h4000, b: 16'h4000, y: 16'h4400};
        vecs[4] = '{sel: 1'b0, a: 16'h3800, b: 16'h4000, y: 16'h3C00};
        vecs[5] = '{sel: 1'b1, a: 16'hC000, b: 16'h4200, y: 16'hC600};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        p1_req0_valid = 1'b0; p1_req1_valid = 1'b0;
        p1_req0_a = '0; p1_req0_b = '0; p1_req1_a = '0; p1_req1_b = '0;
        p1_rsp_ready = 1'b1;

        #12;
        chk("rst_mul_a", mul_a, 16'h0000);
        chk("rst_mul_b", mul_b, 16'h0000);
        chk("rst_rsp_y", rsp_y, 16'h0000);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_readys", {req1_ready, req0_ready}, 2'b00);
        rst = 1'b0;
        step();

        // Single transactions with rsp_ready held high.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].sel) begin
                req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b;
            end else begin
                req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b;
            end
            #1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 10) begin step(); n++; end
            chk("vec_ready", {req1_ready, req0_ready}, vecs[i].sel ? 2'b10 : 2'b01);
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk("vec_busy", busy, 1);
            chk("vec_mul_a", mul_a, vecs[i].a);
            chk("vec_mul_b", mul_b, vecs[i].b);
            n = 0;
            while (!rsp_valid && n < 20) begin step(); n++; end
            chk("vec_latency", n, 2);
            chk("vec_rsp_y", rsp_y, vecs[i].y);
            chk("vec_rsp_id", rsp_id, vecs[i].sel);
            step();
            chk("vec_rsp_cleared", rsp_valid, 0);
            chk("vec_idle", busy, 0);
        end

        // Backpressure with operand change after accept and both requesters waiting.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h4000; req0_b = 16'h4200;
        #1;
        chk("bp_ready0", {req1_ready, req0_ready}, 2'b01);
        step();
        req0_a = 16'hFFFF;
        req1_valid = 1'b1; req1_a = 16'h3C00; req1_b = 16'h3C00;
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("stable_wait_mul_a", mul_a, 16'h4000);
            step();
            n++;
        end
        chk("bp_latency", n, 2);
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_y", rsp_y, 16'h4600);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_readys", {req1_ready, req0_ready}, 2'b00);
            chk("bp_busy", busy, 1);
            chk("stable_done_mul_a", mul_a, 16'h4000);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_readys_at_hs", {req1_ready, req0_ready}, 2'b00);
        step();
        chk("bp_rsp_cleared", rsp_valid, 0);
        chk("bp_idle", busy, 0);
        chk("bp_next_tie", {req1_ready, req0_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0; req0_a = 16'h0000;
        #1;

        // Reset while in WAIT after serving req0 (which would otherwise hand the next tie to req1).
        req0_valid = 1'b1; req0_a = 16'h4000; req0_b = 16'h4200;
        #1;
        step();
        req0_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mrst_mul_a", mul_a, 16'h0000);
        chk("mrst_mul_b", mul_b, 16'h0000);
        chk("mrst_rsp_y", rsp_y, 16'h0000);
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_rsp_id", rsp_id, 0);
        chk("mrst_busy", busy, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin step(); seen = seen | rsp_valid | busy; end
        chk("mrst_no_rsp", seen, 0);

        // Both requesters continuously valid: grants alternate starting with req0.
        req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
        req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h4000;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 10) begin step(); n++; end
            chk("rr_grant", {req1_ready, req0_ready}, (g % 2) ? 2'b10 : 2'b01);
            step();
            n = 0;
            while (!rsp_valid && n < 20) begin step(); n++; end
            chk("rr_latency", n, 2);
            chk("rr_rsp_id", rsp_id, g % 2);
            chk("rr_rsp_y", rsp_y, (g % 2) ? 16'h4400 : 16'h3C00);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;

        // MUL_LAT=1 instance: response one edge after accept.
        p1_req1_valid = 1'b1; p1_req1_a = 16'h0000; p1_req1_b = 16'h4000;
        #1;
        chk("l1_ready", {p1_req1_ready, p1_req0_ready}, 2'b10);
        step();
        p1_req1_valid = 1'b0;
        chk("l1_not_yet", p1_rsp_valid, 0);
        chk("l1_busy", p1_busy, 1);
        step();
        chk("l1_rsp_valid", p1_rsp_valid, 1);
        chk("l1_rsp_y", p1_rsp_y, 16'h0000);
        chk("l1_rsp_id", p1_rsp_id, 1);
        step();
        chk("l1_idle", p1_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
